// File: rtl/rs_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu_if
// Description : Bundle for the ALU reservation station. It carries the global
//               enable, the flush, the dispatch port, both result broadcast
//               buses and the issue port.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_alu_if #(
    parameter int NICK_W = 4,
    parameter int OP_W   = 6
);
    // Global enable and flush
    logic              rdy;
    logic              iROB_clr;

    // Dispatch port
    logic              iDP_en;
    logic [31:0]       iDP_pc;
    logic [OP_W-1:0]   iDP_op;
    logic [31:0]       iDP_imm;
    logic [NICK_W-1:0] iDP_rd_nick;
    logic              iDP_rs1_rdy;
    logic [31:0]       iDP_rs1_dt;
    logic [NICK_W-1:0] iDP_rs1_nick;
    logic              iDP_rs2_rdy;
    logic [31:0]       iDP_rs2_dt;
    logic [NICK_W-1:0] iDP_rs2_nick;

    // Result broadcast buses
    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [31:0]       iEX_dt;
    logic              iLS_en;
    logic [NICK_W-1:0] iLS_nick;
    logic [31:0]       iLS_dt;

    // Station status and issue port
    logic              oRS_full;
    logic              oRS_en;
    logic [31:0]       oRS_pc;
    logic [OP_W-1:0]   oRS_op;
    logic [31:0]       oRS_imm;
    logic [NICK_W-1:0] oRS_rd_nick;
    logic [31:0]       oRS_rs1_dt;
    logic [31:0]       oRS_rs2_dt;

    // Driver side: the dispatcher, the producers and the consumer
    modport master (
        output rdy, iROB_clr,
        output iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
        output iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick,
        output iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
        output iEX_en, iEX_nick, iEX_dt,
        output iLS_en, iLS_nick, iLS_dt,
        input  oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick,
        input  oRS_rs1_dt, oRS_rs2_dt
    );

    // Station side
    modport slave (
        input  rdy, iROB_clr,
        input  iDP_en, iDP_pc, iDP_op, iDP_imm, iDP_rd_nick,
        input  iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick,
        input  iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick,
        input  iEX_en, iEX_nick, iEX_dt,
        input  iLS_en, iLS_nick, iLS_dt,
        output oRS_full, oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick,
        output oRS_rs1_dt, oRS_rs2_dt
    );
endinterface
`default_nettype wire

// File: rtl/rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu
// Description : ALU reservation station. Holds dispatched instructions until
//               both source operands are known, snooping the EX and LS result
//               buses for the producer tags, then issues the lowest-index ready
//               entry, one per cycle, through a registered issue port.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu #(
    parameter int ENTRIES = 16,
    parameter int NICK_W  = 4,
    parameter int OP_W    = 6
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rs_alu_if.slave    bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Slot storage
    logic [ENTRIES-1:0] r_busy;
    logic [31:0]        r_pc      [ENTRIES];
    logic [OP_W-1:0]    r_op      [ENTRIES];
    logic [31:0]        r_imm     [ENTRIES];
    logic [NICK_W-1:0]  r_rd_nick [ENTRIES];
    logic [ENTRIES-1:0] r_rs1_rdy;
    logic [31:0]        r_rs1_dt  [ENTRIES];
    logic [NICK_W-1:0]  r_rs1_nick[ENTRIES];
    logic [ENTRIES-1:0] r_rs2_rdy;
    logic [31:0]        r_rs2_dt  [ENTRIES];
    logic [NICK_W-1:0]  r_rs2_nick[ENTRIES];

    // Issue port registers
    logic               r_o_en;
    logic [31:0]        r_o_pc;
    logic [OP_W-1:0]    r_o_op;
    logic [31:0]        r_o_imm;
    logic [NICK_W-1:0]  r_o_rd_nick;
    logic [31:0]        r_o_rs1_dt;
    logic [31:0]        r_o_rs2_dt;

    // Combinational selection and wakeup results
    logic               w_full;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [32:0]        w_rs1_wk  [ENTRIES];
    logic [32:0]        w_rs2_wk  [ENTRIES];
    logic [32:0]        w_dp_rs1;
    logic [32:0]        w_dp_rs2;
    logic               w_dp_accept;

    // Operand wakeup: returns {rdy, dt}. EX is checked first so it wins when
    // both buses carry the same tag.
    function automatic logic [32:0] wake(
        input logic              op_rdy,
        input logic [31:0]       op_dt,
        input logic [NICK_W-1:0] op_nick,
        input logic              ex_en,
        input logic [NICK_W-1:0] ex_nick,
        input logic [31:0]       ex_dt,
        input logic              ls_en,
        input logic [NICK_W-1:0] ls_nick,
        input logic [31:0]       ls_dt
    );
        if (op_rdy)
            return {1'b1, op_dt};
        if (ex_en && (ex_nick == op_nick))
            return {1'b1, ex_dt};
        if (ls_en && (ls_nick == op_nick))
            return {1'b1, ls_dt};
        return {1'b0, op_dt};
    endfunction

    // Full flag and lowest-index free slot, both from registered busy bits
    always_comb begin
        w_full       = &r_busy;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Lowest-index busy slot with both operands ready in registered state
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_busy[i] && r_rs1_rdy[i] && r_rs2_rdy[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Broadcast capture for every stored operand and for the dispatch bypass
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_rs1_wk[i] = wake(r_rs1_rdy[i], r_rs1_dt[i], r_rs1_nick[i],
                               bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                               bus.iLS_en, bus.iLS_nick, bus.iLS_dt);
            w_rs2_wk[i] = wake(r_rs2_rdy[i], r_rs2_dt[i], r_rs2_nick[i],
                               bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                               bus.iLS_en, bus.iLS_nick, bus.iLS_dt);
        end
        w_dp_rs1 = wake(bus.iDP_rs1_rdy, bus.iDP_rs1_dt, bus.iDP_rs1_nick,
                        bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                        bus.iLS_en, bus.iLS_nick, bus.iLS_dt);
        w_dp_rs2 = wake(bus.iDP_rs2_rdy, bus.iDP_rs2_dt, bus.iDP_rs2_nick,
                        bus.iEX_en, bus.iEX_nick, bus.iEX_dt,
                        bus.iLS_en, bus.iLS_nick, bus.iLS_dt);
        w_dp_accept = bus.iDP_en && !w_full && w_free_found;
    end

    // Slot state and issue register update; rst beats rdy, rdy beats clr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_rs1_rdy   <= '0;
            r_rs2_rdy   <= '0;
            r_o_en      <= 1'b0;
            r_o_pc      <= '0;
            r_o_op      <= '0;
            r_o_imm     <= '0;
            r_o_rd_nick <= '0;
            r_o_rs1_dt  <= '0;
            r_o_rs2_dt  <= '0;
        end else if (bus.rdy) begin
            if (bus.iROB_clr) begin
                r_busy <= '0;
                r_o_en <= 1'b0;
            end else begin
                // Wake waiting operands of occupied slots
                for (int i = 0; i < ENTRIES; i++) begin
                    if (r_busy[i] && !r_rs1_rdy[i])
                        {r_rs1_rdy[i], r_rs1_dt[i]} <= w_rs1_wk[i];
                    if (r_busy[i] && !r_rs2_rdy[i])
                        {r_rs2_rdy[i], r_rs2_dt[i]} <= w_rs2_wk[i];
                end

                // Issue the selected slot; it is busy, so it never collides
                // with the free slot chosen for dispatch below
                r_o_en <= w_sel_found;
                if (w_sel_found) begin
                    r_o_pc              <= r_pc[w_sel_idx];
                    r_o_op              <= r_op[w_sel_idx];
                    r_o_imm             <= r_imm[w_sel_idx];
                    r_o_rd_nick         <= r_rd_nick[w_sel_idx];
                    r_o_rs1_dt          <= r_rs1_dt[w_sel_idx];
                    r_o_rs2_dt          <= r_rs2_dt[w_sel_idx];
                    r_busy[w_sel_idx]   <= 1'b0;
                end

                // Dispatch into the lowest free slot seen before this issue
                if (w_dp_accept) begin
                    r_busy[w_free_idx]     <= 1'b1;
                    r_pc[w_free_idx]       <= bus.iDP_pc;
                    r_op[w_free_idx]       <= bus.iDP_op;
                    r_imm[w_free_idx]      <= bus.iDP_imm;
                    r_rd_nick[w_free_idx]  <= bus.iDP_rd_nick;
                    r_rs1_rdy[w_free_idx]  <= w_dp_rs1[32];
                    r_rs1_dt[w_free_idx]   <= w_dp_rs1[31:0];
                    r_rs1_nick[w_free_idx] <= bus.iDP_rs1_nick;
                    r_rs2_rdy[w_free_idx]  <= w_dp_rs2[32];
                    r_rs2_dt[w_free_idx]   <= w_dp_rs2[31:0];
                    r_rs2_nick[w_free_idx] <= bus.iDP_rs2_nick;
                end
            end
        end
    end

    assign bus.oRS_full    = w_full;
    assign bus.oRS_en      = r_o_en;
    assign bus.oRS_pc      = r_o_pc;
    assign bus.oRS_op      = r_o_op;
    assign bus.oRS_imm     = r_o_imm;
    assign bus.oRS_rd_nick = r_o_rd_nick;
    assign bus.oRS_rs1_dt  = r_o_rs1_dt;
    assign bus.oRS_rs2_dt  = r_o_rs2_dt;
endmodule
`default_nettype wire

// File: tb/tb_rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_alu
// Description : Directed self-checking bench for the ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_alu;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rs_alu_if #(.NICK_W(4), .OP_W(6)) bus ();

    rs_alu #(.ENTRIES(16), .NICK_W(4), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return all driven inputs to idle with the station enabled
    task automatic idle();
        bus.rdy          = 1'b1;
        bus.iROB_clr     = 1'b0;
        bus.iDP_en       = 1'b0;
        bus.iDP_pc       = '0;
        bus.iDP_op       = '0;
        bus.iDP_imm      = '0;
        bus.iDP_rd_nick  = '0;
        bus.iDP_rs1_rdy  = 1'b1;
        bus.iDP_rs1_dt   = '0;
        bus.iDP_rs1_nick = '0;
        bus.iDP_rs2_rdy  = 1'b1;
        bus.iDP_rs2_dt   = '0;
        bus.iDP_rs2_nick = '0;
        bus.iEX_en       = 1'b0;
        bus.iEX_nick     = '0;
        bus.iEX_dt       = '0;
        bus.iLS_en       = 1'b0;
        bus.iLS_nick     = '0;
        bus.iLS_dt       = '0;
    endtask

    // Present one dispatch on the bus
    task automatic dp(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                      input logic [3:0] rd, input logic r1, input logic [31:0] d1,
                      input logic [3:0] n1, input logic r2, input logic [31:0] d2,
                      input logic [3:0] n2);
        bus.iDP_en       = 1'b1;
        bus.iDP_pc       = pc;
        bus.iDP_op       = op;
        bus.iDP_imm      = imm;
        bus.iDP_rd_nick  = rd;
        bus.iDP_rs1_rdy  = r1;
        bus.iDP_rs1_dt   = d1;
        bus.iDP_rs1_nick = n1;
        bus.iDP_rs2_rdy  = r2;
        bus.iDP_rs2_dt   = d2;
        bus.iDP_rs2_nick = n2;
    endtask

    task automatic flush();
        idle();
        bus.iROB_clr = 1'b1;
        step();
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_en",   64'(bus.oRS_en), 64'd0);
        chk("rst_full", 64'(bus.oRS_full), 64'd0);
        chk("rst_pc",   64'(bus.oRS_pc), 64'd0);
        chk("rst_imm",  64'(bus.oRS_imm), 64'd0);
        chk("rst_rs1",  64'(bus.oRS_rs1_dt), 64'd0);

        // Ready ADDI: issue after the following edge, single cycle
        dp(32'h100, 6'h13, 32'd3, 4'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        idle();
        chk("addi_lat0", 64'(bus.oRS_en), 64'd0);
        step();
        chk("addi_en",   64'(bus.oRS_en), 64'd1);
        chk("addi_rs1",  64'(bus.oRS_rs1_dt), 64'd5);
        chk("addi_imm",  64'(bus.oRS_imm), 64'd3);
        chk("addi_rd",   64'(bus.oRS_rd_nick), 64'd2);
        chk("addi_op",   64'(bus.oRS_op), 64'h13);
        chk("addi_pc",   64'(bus.oRS_pc), 64'h100);
        step();
        chk("addi_once", 64'(bus.oRS_en), 64'd0);
        chk("addi_hold", 64'(bus.oRS_pc), 64'h100);

        // rs1 waits on nick 7; a wrong tag must not wake it
        dp(32'h200, 6'h01, 32'd0, 4'd1, 1'b0, 32'd0, 4'd7, 1'b1, 32'd9, 4'd0);
        step();
        idle();
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd6; bus.iEX_dt = 32'hBAD;
        step();
        idle();
        step();
        chk("wrong_nick", 64'(bus.oRS_en), 64'd0);
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd7; bus.iEX_dt = 32'h1234;
        step();
        idle();
        chk("ex_wait", 64'(bus.oRS_en), 64'd0);
        step();
        chk("ex_en",  64'(bus.oRS_en), 64'd1);
        chk("ex_rs1", 64'(bus.oRS_rs1_dt), 64'h1234);
        chk("ex_rs2", 64'(bus.oRS_rs2_dt), 64'd9);

        // Bypass: rs2 waits on nick 3 while LS broadcasts it
        dp(32'h300, 6'h02, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd3);
        bus.iLS_en = 1'b1; bus.iLS_nick = 4'd3; bus.iLS_dt = 32'hFF;
        step();
        idle();
        step();
        chk("byp_en",  64'(bus.oRS_en), 64'd1);
        chk("byp_rs2", 64'(bus.oRS_rs2_dt), 64'hFF);

        // Both buses carry the same tag: EX data wins
        dp(32'h400, 6'h03, 32'd0, 4'd4, 1'b0, 32'd0, 4'd4, 1'b1, 32'd0, 4'd0);
        step();
        idle();
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd4; bus.iEX_dt = 32'hAAAA;
        bus.iLS_en = 1'b1; bus.iLS_nick = 4'd4; bus.iLS_dt = 32'hBBBB;
        step();
        idle();
        step();
        chk("both_en",  64'(bus.oRS_en), 64'd1);
        chk("both_rs1", 64'(bus.oRS_rs1_dt), 64'hAAAA);

        // Fill all 16 slots, slot i waiting on nick i
        for (int i = 0; i < 16; i++) begin
            dp(32'h1000 + 32'(i * 4), 6'h04, 32'd0, 4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0);
            step();
        end
        chk("full_set", 64'(bus.oRS_full), 64'd1);
        dp(32'hDEAD, 6'h05, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        idle();
        chk("full_ign0", 64'(bus.oRS_en), 64'd0);
        step();
        chk("full_ign1", 64'(bus.oRS_en), 64'd0);
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd5; bus.iEX_dt = 32'h55;
        step();
        idle();
        chk("full_still", 64'(bus.oRS_full), 64'd1);
        step();
        chk("wk5_en",   64'(bus.oRS_en), 64'd1);
        chk("wk5_pc",   64'(bus.oRS_pc), 64'h1014);
        chk("wk5_rs1",  64'(bus.oRS_rs1_dt), 64'h55);
        chk("full_drop", 64'(bus.oRS_full), 64'd0);
        // Refill waits on nick 15, like slot 15; lower index issues first
        dp(32'h2000, 6'h06, 32'd0, 4'd9, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
        step();
        idle();
        chk("refill_full", 64'(bus.oRS_full), 64'd1);
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd15; bus.iEX_dt = 32'hF0;
        step();
        idle();
        step();
        chk("refill_pc",  64'(bus.oRS_pc), 64'h2000);
        chk("refill_rs1", 64'(bus.oRS_rs1_dt), 64'hF0);
        step();
        chk("slot15_en", 64'(bus.oRS_en), 64'd1);
        chk("slot15_pc", 64'(bus.oRS_pc), 64'h103C);
        step();
        chk("slot15_once", 64'(bus.oRS_en), 64'd0);
        flush();

        // Slots 0 and 5 become ready together
        for (int i = 0; i < 6; i++) begin
            dp(32'h6000 + 32'(i * 4), 6'h07, 32'd0, 4'd0, 1'b0, 32'd0,
               (i == 0 || i == 5) ? 4'd10 : 4'd11, 1'b1, 32'd0, 4'd0);
            step();
        end
        idle();
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd10; bus.iEX_dt = 32'h10;
        step();
        idle();
        step();
        chk("prio_first",  64'(bus.oRS_pc), 64'h6000);
        step();
        chk("prio_second", 64'(bus.oRS_pc), 64'h6014);
        chk("prio_en",     64'(bus.oRS_en), 64'd1);
        step();
        chk("prio_done",   64'(bus.oRS_en), 64'd0);
        flush();

        // Flush with 4 busy slots, concurrent dispatch and wakeup
        for (int i = 0; i < 4; i++) begin
            dp(32'h7000 + 32'(i * 4), 6'h08, 32'd0, 4'd0, 1'b0, 32'd0, 4'd12, 1'b1, 32'd0, 4'd0);
            step();
        end
        dp(32'h7100, 6'h08, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        bus.iROB_clr = 1'b1;
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd12; bus.iEX_dt = 32'h12;
        step();
        idle();
        chk("clr_en",   64'(bus.oRS_en), 64'd0);
        chk("clr_full", 64'(bus.oRS_full), 64'd0);
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd12; bus.iEX_dt = 32'h12;
        step();
        idle();
        step();
        chk("clr_none0", 64'(bus.oRS_en), 64'd0);
        step();
        chk("clr_none1", 64'(bus.oRS_en), 64'd0);
        // Flush on the cycle a ready entry would issue
        dp(32'h7200, 6'h08, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        idle();
        bus.iROB_clr = 1'b1;
        step();
        idle();
        chk("clr_issue", 64'(bus.oRS_en), 64'd0);
        step();
        chk("clr_after", 64'(bus.oRS_en), 64'd0);

        // Freeze for 3 cycles while an issue is showing
        dp(32'h8000, 6'h09, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        dp(32'h8004, 6'h09, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        step();
        chk("frz_pre_en", 64'(bus.oRS_en), 64'd1);
        chk("frz_pre_pc", 64'(bus.oRS_pc), 64'h8000);
        dp(32'h8008, 6'h09, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
        bus.rdy = 1'b0;
        bus.iROB_clr = 1'b1;
        bus.iEX_en = 1'b1; bus.iEX_nick = 4'd1; bus.iEX_dt = 32'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_en", 64'(bus.oRS_en), 64'd1);
            chk("frz_pc", 64'(bus.oRS_pc), 64'h8000);
        end
        idle();
        step();
        chk("resume_en", 64'(bus.oRS_en), 64'd1);
        chk("resume_pc", 64'(bus.oRS_pc), 64'h8004);
        step();
        chk("resume_end", 64'(bus.oRS_en), 64'd0);
        step();
        chk("resume_none", 64'(bus.oRS_en), 64'd0);

        // Reset takes priority over a low enable
        bus.rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("rstprio_pc", 64'(bus.oRS_pc), 64'd0);
        chk("rstprio_rd", 64'(bus.oRS_rd_nick), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rs_alu.md
RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of station slots (power of two, 2..32).
REQ-002 SHALL have parameter NICK_W, default 4, ROB tag (nick) width.
REQ-003 SHALL have parameter OP_W, default 6, decoded opcode width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port rdy  in  1  global enable; low freezes all state and outputs.
REQ-007 SHALL have port iROB_clr  in  1  mispredict flush.
REQ-008 SHALL have port iDP_en  in  1  dispatch valid.
REQ-009 SHALL have ports iDP_pc 32, iDP_op OP_W, iDP_imm 32, iDP_rd_nick NICK_W  in  dispatched instruction fields.
REQ-010 SHALL have ports iDP_rs1_rdy 1, iDP_rs1_dt 32, iDP_rs1_nick NICK_W (same set for rs2)  in  operand value or producer tag.
REQ-011 SHALL have ports iEX_en 1, iEX_nick NICK_W, iEX_dt 32  in  ALU result broadcast.
REQ-012 SHALL have ports iLS_en 1, iLS_nick NICK_W, iLS_dt 32  in  load/store unit result broadcast.
REQ-013 SHALL have port oRS_full  out  1  no free slot (combinational from registered state).
REQ-014 SHALL have ports oRS_en 1, oRS_pc 32, oRS_op OP_W, oRS_imm 32, oRS_rd_nick NICK_W, oRS_rs1_dt 32, oRS_rs2_dt 32  out  registered issue to execute.

Function
REQ-015 SHALL hold per slot: busy, pc, op, imm, rd_nick, and per operand rdy, dt, nick.
REQ-016 SHALL accept dispatch only when iDP_en=1 and oRS_full=0; dispatch while full SHALL be ignored with no state change.
REQ-017 SHALL write accepted dispatch into lowest-index free slot, busy=1 next edge.
REQ-018 SHALL, for each waiting operand (rdy=0) of each busy slot, capture dt and set rdy=1 when iEX_en=1 and iEX_nick matches, or iLS_en=1 and iLS_nick matches.
REQ-019 SHALL apply the same capture to operands being dispatched this cycle (bypass): a non-ready dispatched operand whose nick matches a broadcast this cycle enters ready.
REQ-020 SHALL, if both buses broadcast the same nick, take iEX_dt.
REQ-021 SHALL each cycle select the lowest-index busy slot whose rs1 and rs2 are both rdy in current registered state; selected slot's fields drive oRS_* at next edge with oRS_en=1, and slot busy clears at that edge.
REQ-022 SHALL drive oRS_en=0 on edges with no selectable slot; other oRS_* hold last values.
REQ-023 SHALL issue at most one instruction per cycle; latency dispatch-with-ready-operands at edge N -> oRS_en=1 after edge N+1.
REQ-024 SHALL allow a slot freed by issue and a new dispatch in the same cycle; dispatch uses free state before the issue clear (freed slot reusable next cycle).
REQ-025 SHALL, on iROB_clr=1, clear all busy bits and oRS_en at next edge; clr SHALL override dispatch, capture and issue that cycle.
REQ-026 SHALL, with rdy=0, ignore dispatch, broadcasts, clr and issue; broadcasts during rdy=0 are lost (producers honour rdy too).
REQ-027 SHALL assert oRS_full exactly when all ENTRIES slots busy.
REQ-028 SHALL not depend on op semantics; dispatcher presets rdy=1 for unused operands.

Reset
REQ-029 SHALL on rst=1 clear all busy bits and operand rdy bits.
REQ-030 SHALL on rst=1 drive oRS_en=0 and oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt to 0; oRS_full=0 after reset.
REQ-031 SHALL give rst priority over rdy, iROB_clr and all other inputs.

Verification
REQ-032 SHALL verify: dispatch ADDI rs1_rdy=1 dt=5, rs2_rdy=1, imm=3, nick=2 at edge N -> oRS_en=1, rs1_dt=5, imm=3, rd_nick=2 after edge N+1, single cycle.
REQ-033 SHALL verify: dispatch rs1 waiting nick=7, then iEX_en nick=7 dt=0x1234 -> issue one cycle after broadcast with oRS_rs1_dt=0x1234.
REQ-034 SHALL verify: dispatch rs2 waiting nick=3 concurrent with iLS_en nick=3 dt=0xFF -> issues next cycle with rs2_dt=0xFF (bypass).
REQ-035 SHALL verify: 16 non-ready dispatches -> oRS_full=1, 17th dispatch ignored; one wakeup -> issue, full drops, refill slot same index.
REQ-036 SHALL verify: slots 0 and 5 ready same cycle -> slot 0 issues first, slot 5 next cycle.
REQ-037 SHALL verify: iROB_clr with 4 busy slots and concurrent dispatch -> all empty, oRS_en=0 next cycle, no later issue; rdy=0 for 3 cycles mid-stream -> outputs frozen, resume unchanged.
